// File: rtl/reverb_i2s_tx_if.sv
// Sample bus from the reverb core into the I2S transmitter.
// The reverb side drives a packed {left, right} result and a done strobe.
interface reverb_i2s_tx_if #(
   parameter int DAC_DATA_WIDTH = 38
);
   logic [DAC_DATA_WIDTH-1:0] Reverb_Out;
   logic                      reverb_Done;

   modport master (
      output Reverb_Out,
      output reverb_Done
   );

   modport slave (
      input Reverb_Out,
      input reverb_Done
   );
endinterface

// File: rtl/reverb_i2s_tx.sv
// Saturates stereo reverb samples, double-buffers one frame and serialises it
// as a Philips I2S master stream with sticky overrun/underrun reporting.
module reverb_i2s_tx #(
   parameter int SINGLE_DAC_WIDTH = 19,
   parameter int DAC_DATA_WIDTH   = 38,
   parameter int OUT_WIDTH        = 16,
   parameter int SLOT_BITS        = 32,
   parameter int BCLK_DIV         = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   reverb_i2s_tx_if.slave       rev_if,
   output logic                 i2s_bclk,
   output logic                 i2s_lrck,
   output logic                 i2s_sdata,
   output logic                 frame_start,
   output logic                 underrun,
   output logic                 overrun
);

   localparam int PW = $clog2(2 * SLOT_BITS);
   localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

   localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
   localparam logic [PW-1:0] P_LAST   = PW'(2 * SLOT_BITS - 1);
   localparam logic [PW-1:0] P_SLOT   = PW'(SLOT_BITS);
   localparam logic [PW-1:0] P_ONE    = PW'(1);
   localparam logic [PW-1:0] P_LEND   = PW'(OUT_WIDTH);
   localparam logic [PW-1:0] P_RBEG   = PW'(SLOT_BITS + 1);
   localparam logic [PW-1:0] P_REND   = PW'(SLOT_BITS + OUT_WIDTH);

   typedef enum logic {
      ST_WAIT_FIRST,
      ST_RUN
   } state_e;

   state_e                 state_q, state_d;
   logic [DW-1:0]          divCnt_q, divCnt_d;
   logic [PW-1:0]          framePos_q, framePos_d;
   logic                   bclk_q, bclk_d;
   logic                   lrck_q, lrck_d;
   logic                   sdata_q, sdata_d;
   logic                   frameStart_q, frameStart_d;
   logic                   underrun_q, underrun_d;
   logic                   overrun_q, overrun_d;
   logic                   doneDly_q, doneDly_d;
   logic                   holdValid_q, holdValid_d;
   logic [OUT_WIDTH-1:0]   holdL_q, holdL_d;
   logic [OUT_WIDTH-1:0]   holdR_q, holdR_d;
   logic [OUT_WIDTH-1:0]   shiftL_q, shiftL_d;
   logic [OUT_WIDTH-1:0]   shiftR_q, shiftR_d;

   logic signed [SINGLE_DAC_WIDTH-1:0] inL, inR;
   logic [OUT_WIDTH-1:0]               satL, satR;
   logic                               doneRise;
   logic                               shiftEv;
   logic                               load;

   assign inL = rev_if.Reverb_Out[DAC_DATA_WIDTH-1 -: SINGLE_DAC_WIDTH];
   assign inR = rev_if.Reverb_Out[SINGLE_DAC_WIDTH-1:0];

   // A narrower DAC needs clamping; a wider one just takes the sign-extended value.
   generate
      if (OUT_WIDTH >= SINGLE_DAC_WIDTH) begin : g_extend
         assign satL = OUT_WIDTH'(inL);
         assign satR = OUT_WIDTH'(inR);
      end else begin : g_clamp
         localparam int HB = SINGLE_DAC_WIDTH - OUT_WIDTH + 1;
         localparam logic [OUT_WIDTH-1:0] MAXV = {1'b0, {(OUT_WIDTH-1){1'b1}}};
         localparam logic [OUT_WIDTH-1:0] MINV = {1'b1, {(OUT_WIDTH-1){1'b0}}};

         function automatic logic [OUT_WIDTH-1:0] clampSample(
            input logic [SINGLE_DAC_WIDTH-1:0] x
         );
            logic [HB-1:0] top;
            top = x[SINGLE_DAC_WIDTH-1:OUT_WIDTH-1];
            if (top == '0 || top == '1) begin
               clampSample = x[OUT_WIDTH-1:0];
            end else if (x[SINGLE_DAC_WIDTH-1]) begin
               clampSample = MINV;
            end else begin
               clampSample = MAXV;
            end
         endfunction

         assign satL = clampSample(inL);
         assign satR = clampSample(inR);
      end
   endgenerate

   always_comb begin
      state_d      = state_q;
      divCnt_d     = divCnt_q;
      framePos_d   = framePos_q;
      bclk_d       = bclk_q;
      lrck_d       = lrck_q;
      sdata_d      = sdata_q;
      frameStart_d = 1'b0;
      underrun_d   = underrun_q;
      overrun_d    = overrun_q;
      doneDly_d    = rev_if.reverb_Done;
      holdValid_d  = holdValid_q;
      holdL_d      = holdL_q;
      holdR_d      = holdR_q;
      shiftL_d     = shiftL_q;
      shiftR_d     = shiftR_q;
      doneRise     = rev_if.reverb_Done & ~doneDly_q;
      shiftEv      = 1'b0;
      load         = 1'b0;

      if (divCnt_q == DIV_LAST) begin
         divCnt_d = '0;
         bclk_d   = ~bclk_q;
         shiftEv  = bclk_q;
      end else begin
         divCnt_d = divCnt_q + DW'(1);
      end

      // The first shift event after reset starts a frame at position 0 rather than advancing.
      if (shiftEv) begin
         state_d = ST_RUN;
         if (state_q == ST_WAIT_FIRST || framePos_q == P_LAST) begin
            framePos_d = '0;
         end else begin
            framePos_d = framePos_q + PW'(1);
         end
         load    = (framePos_d == '0);
         lrck_d  = (framePos_d >= P_SLOT);
         sdata_d = 1'b0;
         if (framePos_d >= P_ONE && framePos_d <= P_LEND) begin
            sdata_d  = shiftL_q[OUT_WIDTH-1];
            shiftL_d = shiftL_q << 1;
         end else if (framePos_d >= P_RBEG && framePos_d <= P_REND) begin
            sdata_d  = shiftR_q[OUT_WIDTH-1];
            shiftR_d = shiftR_q << 1;
         end
      end

      if (load) begin
         frameStart_d = 1'b1;
         if (holdValid_q) begin
            shiftL_d    = holdL_q;
            shiftR_d    = holdR_q;
            holdValid_d = 1'b0;
         end else begin
            shiftL_d   = '0;
            shiftR_d   = '0;
            underrun_d = 1'b1;
         end
      end

      // A capture coinciding with a load refills the buffer the load just drained.
      if (doneRise) begin
         holdL_d     = satL;
         holdR_d     = satR;
         holdValid_d = 1'b1;
         if (holdValid_q && !load) begin
            overrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_WAIT_FIRST;
         divCnt_q     <= '0;
         framePos_q   <= '0;
         bclk_q       <= 1'b0;
         lrck_q       <= 1'b0;
         sdata_q      <= 1'b0;
         frameStart_q <= 1'b0;
         underrun_q   <= 1'b0;
         overrun_q    <= 1'b0;
         doneDly_q    <= 1'b0;
         holdValid_q  <= 1'b0;
         holdL_q      <= '0;
         holdR_q      <= '0;
         shiftL_q     <= '0;
         shiftR_q     <= '0;
      end else begin
         state_q      <= state_d;
         divCnt_q     <= divCnt_d;
         framePos_q   <= framePos_d;
         bclk_q       <= bclk_d;
         lrck_q       <= lrck_d;
         sdata_q      <= sdata_d;
         frameStart_q <= frameStart_d;
         underrun_q   <= underrun_d;
         overrun_q    <= overrun_d;
         doneDly_q    <= doneDly_d;
         holdValid_q  <= holdValid_d;
         holdL_q      <= holdL_d;
         holdR_q      <= holdR_d;
         shiftL_q     <= shiftL_d;
         shiftR_q     <= shiftR_d;
      end
   end

   assign i2s_bclk    = bclk_q;
   assign i2s_lrck    = lrck_q;
   assign i2s_sdata   = sdata_q;
   assign frame_start = frameStart_q;
   assign underrun    = underrun_q;
   assign overrun     = overrun_q;

endmodule

// File: tb/tb_reverb_i2s_tx.sv
// Directed bench for reverb_i2s_tx: decodes whole I2S frames and checks
// saturation, buffering, underrun/overrun flags and reset behaviour.
`timescale 1ns/1ps
module tb_reverb_i2s_tx;

   logic clk;
   logic rst_n;
   logic i2s_bclk;
   logic i2s_lrck;
   logic i2s_sdata;
   logic frame_start;
   logic underrun;
   logic overrun;

   int checks;
   int failures;

   reverb_i2s_tx_if #(.DAC_DATA_WIDTH(38)) rev ();

   reverb_i2s_tx #(
      .SINGLE_DAC_WIDTH (19),
      .DAC_DATA_WIDTH   (38),
      .OUT_WIDTH        (16),
      .SLOT_BITS        (32),
      .BCLK_DIV         (2)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rev_if      (rev.slave),
      .i2s_bclk    (i2s_bclk),
      .i2s_lrck    (i2s_lrck),
      .i2s_sdata   (i2s_sdata),
      .frame_start (frame_start),
      .underrun    (underrun),
      .overrun     (overrun)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // One Done pulse with a low cycle after it so back-to-back calls still form rising edges.
   task automatic applyStimulus(input logic [18:0] left, input logic [18:0] right);
      rev.Reverb_Out  = {left, right};
      rev.reverb_Done = 1'b1;
      @(negedge clk);
      rev.reverb_Done = 1'b0;
      @(negedge clk);
   endtask

   // Waits for frame_start, then samples one bit per BCLK period for positions 0..63.
   task automatic receiveFrame(output logic [15:0] left, output logic [15:0] right,
                               output int padErr, output int lrErr,
                               output time tStart, output logic gotIt);
      int waitCnt;
      waitCnt = 0;
      left    = '0;
      right   = '0;
      padErr  = 0;
      lrErr   = 0;
      tStart  = 0;
      gotIt   = 1'b0;
      while (frame_start !== 1'b1 && waitCnt < 600) begin
         @(negedge clk);
         waitCnt++;
      end
      if (frame_start === 1'b1) begin
         gotIt  = 1'b1;
         tStart = $time;
         for (int k = 0; k < 64; k++) begin
            if (k > 0) repeat (4) @(negedge clk);
            if (i2s_lrck !== (k >= 32)) lrErr++;
            if (k >= 1 && k <= 16) begin
               left = {left[14:0], i2s_sdata};
            end else if (k >= 33 && k <= 48) begin
               right = {right[14:0], i2s_sdata};
            end else if (i2s_sdata !== 1'b0) begin
               padErr++;
            end
         end
      end
   endtask

   initial begin
      logic [15:0] fl, fr;
      int          padErr, lrErr, fsCnt;
      time         tPrev, tCur;
      logic        got;

      checks          = 0;
      failures        = 0;
      rev.Reverb_Out  = '0;
      rev.reverb_Done = 1'b0;
      rst_n           = 1'b1;
      #3 rst_n        = 1'b0;
      repeat (3) @(negedge clk);

      checkOutput("rst_bclk", {31'd0, i2s_bclk}, 32'd0);
      checkOutput("rst_lrck", {31'd0, i2s_lrck}, 32'd0);
      checkOutput("rst_sdata", {31'd0, i2s_sdata}, 32'd0);
      checkOutput("rst_fstart", {31'd0, frame_start}, 32'd0);
      checkOutput("rst_underrun", {31'd0, underrun}, 32'd0);
      checkOutput("rst_overrun", {31'd0, overrun}, 32'd0);

      // Capture lands before the first shift event, so the very first frame carries it.
      rst_n = 1'b1;
      applyStimulus(19'h01234, 19'h7EDCC);
      receiveFrame(fl, fr, padErr, lrErr, tPrev, got);
      checkOutput("f1_got", {31'd0, got}, 32'd1);
      checkOutput("f1_left", {16'd0, fl}, 32'h1234);
      checkOutput("f1_right", {16'd0, fr}, 32'hEDCC);
      checkOutput("f1_pad", padErr, 32'd0);
      checkOutput("f1_lrck", lrErr, 32'd0);
      checkOutput("f1_underrun", {31'd0, underrun}, 32'd0);
      checkOutput("f1_overrun", {31'd0, overrun}, 32'd0);

      applyStimulus(19'h3FFFF, 19'h40000);
      receiveFrame(fl, fr, padErr, lrErr, tPrev, got);
      checkOutput("f2_got", {31'd0, got}, 32'd1);
      checkOutput("f2_left_max", {16'd0, fl}, 32'h7FFF);
      checkOutput("f2_right_min", {16'd0, fr}, 32'h8000);

      applyStimulus(19'h7FFFF, 19'h00001);
      receiveFrame(fl, fr, padErr, lrErr, tPrev, got);
      checkOutput("f3_got", {31'd0, got}, 32'd1);
      checkOutput("f3_left_neg1", {16'd0, fl}, 32'hFFFF);
      checkOutput("f3_right", {16'd0, fr}, 32'h0001);
      checkOutput("f3_underrun", {31'd0, underrun}, 32'd0);

      receiveFrame(fl, fr, padErr, lrErr, tCur, got);
      checkOutput("f4_got", {31'd0, got}, 32'd1);
      checkOutput("f4_left_zero", {16'd0, fl}, 32'h0000);
      checkOutput("f4_right_zero", {16'd0, fr}, 32'h0000);
      checkOutput("f4_pad", padErr, 32'd0);
      checkOutput("f4_underrun", {31'd0, underrun}, 32'd1);
      checkOutput("f4_period", 32'(tCur - tPrev), 32'd2560);

      applyStimulus(19'h00111, 19'h00222);
      checkOutput("f5_no_ovr_yet", {31'd0, overrun}, 32'd0);
      applyStimulus(19'h00333, 19'h00444);
      receiveFrame(fl, fr, padErr, lrErr, tCur, got);
      checkOutput("f5_got", {31'd0, got}, 32'd1);
      checkOutput("f5_left_B", {16'd0, fl}, 32'h0333);
      checkOutput("f5_right_B", {16'd0, fr}, 32'h0444);
      checkOutput("f5_overrun", {31'd0, overrun}, 32'd1);

      // Fresh reset so the held-Done case starts with clean sticky flags.
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rev.Reverb_Out  = {19'h00ABC, 19'h7F000};
      rev.reverb_Done = 1'b1;
      rst_n           = 1'b1;
      receiveFrame(fl, fr, padErr, lrErr, tCur, got);
      checkOutput("h1_got", {31'd0, got}, 32'd1);
      checkOutput("h1_left", {16'd0, fl}, 32'h0ABC);
      checkOutput("h1_right", {16'd0, fr}, 32'hF000);
      receiveFrame(fl, fr, padErr, lrErr, tCur, got);
      checkOutput("h2_data", {fl, fr}, 32'h0000_0000);
      receiveFrame(fl, fr, padErr, lrErr, tCur, got);
      checkOutput("h3_data", {fl, fr}, 32'h0000_0000);
      checkOutput("h_underrun", {31'd0, underrun}, 32'd1);
      checkOutput("h_overrun", {31'd0, overrun}, 32'd0);

      rev.reverb_Done = 1'b0;
      @(negedge clk);
      applyStimulus(19'h00000, 19'h00100);
      fsCnt = 0;
      while (frame_start !== 1'b1 && fsCnt < 600) begin
         @(negedge clk);
         fsCnt++;
      end
      checkOutput("m_fstart_seen", {31'd0, frame_start}, 32'd1);
      repeat (162) @(negedge clk);
      checkOutput("m_pre_bclk", {31'd0, i2s_bclk}, 32'd1);
      checkOutput("m_pre_lrck", {31'd0, i2s_lrck}, 32'd1);
      checkOutput("m_pre_sdata", {31'd0, i2s_sdata}, 32'd1);

      rst_n = 1'b0;
      #1;
      checkOutput("m_rst_bclk", {31'd0, i2s_bclk}, 32'd0);
      checkOutput("m_rst_lrck", {31'd0, i2s_lrck}, 32'd0);
      checkOutput("m_rst_sdata", {31'd0, i2s_sdata}, 32'd0);
      checkOutput("m_rst_underrun", {31'd0, underrun}, 32'd0);
      repeat (3) @(negedge clk);

      rev.Reverb_Out  = {19'h05A5A, 19'h7C3C3};
      rev.reverb_Done = 1'b1;
      rst_n           = 1'b1;
      @(negedge clk);
      rev.reverb_Done = 1'b0;
      fsCnt = 1;
      while (frame_start !== 1'b1 && fsCnt < 20) begin
         @(negedge clk);
         fsCnt++;
      end
      checkOutput("m_first_fstart", fsCnt, 32'd4);
      receiveFrame(fl, fr, padErr, lrErr, tCur, got);
      checkOutput("m_got", {31'd0, got}, 32'd1);
      checkOutput("m_left", {16'd0, fl}, 32'h5A5A);
      checkOutput("m_right", {16'd0, fr}, 32'hC3C3);
      checkOutput("m_lrck", lrErr, 32'd0);
      checkOutput("m_underrun", {31'd0, underrun}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
